agg_seq_ctrl: RTL and testbench

// Layer sequencer for the aggregator datapath. For each of cfg_n_out neurons it clears the MAC,

---
 rtl/agg_seq_ctrl.sv | 117 +++++++++++
 tb/tb_agg_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/agg_seq_ctrl.sv
// agg_seq_ctrl: layer sequencer that drives the MAC through clear/accumulate/drain for each neuron
// and writes each aggregated result to the result buffer, pulsing done at the end of the layer.
module agg_seq_ctrl #(
   parameter int AGG_WIDTH = 12,
   parameter int N_IN      = 16,
   parameter int N_OUT     = 8,
   parameter int IN_CW     = 5,
   parameter int OUT_CW    = 4,
   parameter int DRAIN_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [IN_CW-1:0]     cfg_n_in,
   input  logic [OUT_CW-1:0]    cfg_n_out,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 mac_clr,
   output logic                 mac_en,
   output logic [IN_CW-1:0]     in_idx,
   input  logic                 agg_out_acted,
   input  logic [AGG_WIDTH-1:0] agg_out2alu,
   output logic                 res_we,
   output logic [OUT_CW-1:0]    res_addr,
   output logic                 res_bit,
   output logic [AGG_WIDTH-1:0] res_sum,
   output logic                 busy,
   output logic                 done
);
   localparam int DCW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(DRAIN_CYC - 1);
   localparam logic [DCW-1:0]    DRAIN_ONE  = DCW'(1);
   localparam logic [IN_CW-1:0]  IN_ONE     = IN_CW'(1);
   localparam logic [IN_CW-1:0]  IN_MAX     = IN_CW'(N_IN);
   localparam logic [OUT_CW-1:0] OUT_ONE    = OUT_CW'(1);
   localparam logic [OUT_CW-1:0] OUT_MAX    = OUT_CW'(N_OUT);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_ACC, S_DRAIN, S_WB, S_DONE} state_t;

   state_t            state, state_nx;
   logic [IN_CW-1:0]  n_in;
   logic [OUT_CW-1:0] n_out, out_idx;
   logic [DCW-1:0]    drain_cnt;

   function automatic logic [IN_CW-1:0] clamp_in(input logic [IN_CW-1:0] v);
      return (v == '0) ? IN_ONE : (v > IN_MAX) ? IN_MAX : v;
   endfunction

   function automatic logic [OUT_CW-1:0] clamp_out(input logic [OUT_CW-1:0] v);
      return (v == '0) ? OUT_ONE : (v > OUT_MAX) ? OUT_MAX : v;
   endfunction

   assign busy     = state != S_IDLE;
   assign in_ready = state == S_ACC;
   assign mac_clr  = state == S_CLR;
   assign mac_en   = in_ready & in_valid;
   assign res_we   = state == S_WB;
   assign done     = state == S_DONE;
   assign res_addr = res_we ? out_idx : '0;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = start ? S_CLR : S_IDLE;
         S_CLR:   state_nx = S_ACC;
         S_ACC:   state_nx = (in_valid && in_idx == n_in - IN_ONE) ? S_DRAIN : S_ACC;
         S_DRAIN: state_nx = (drain_cnt == DRAIN_LAST) ? S_WB : S_DRAIN;
         S_WB:    state_nx = (out_idx == n_out - OUT_ONE) ? S_DONE : S_CLR;
         default: state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         n_in      <= '0;
         n_out     <= '0;
         in_idx    <= '0;
         out_idx   <= '0;
         drain_cnt <= '0;
         res_bit   <= 1'b0;
         res_sum   <= '0;
      end else begin
         state <= state_nx;
         if (abort) begin
            in_idx    <= '0;
            out_idx   <= '0;
            drain_cnt <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  in_idx    <= '0;
                  out_idx   <= '0;
                  drain_cnt <= '0;
                  if (start) begin
                     n_in  <= clamp_in(cfg_n_in);
                     n_out <= clamp_out(cfg_n_out);
                  end
               end
               S_ACC:   if (in_valid) in_idx <= in_idx + IN_ONE;
               S_DRAIN: drain_cnt <= drain_cnt + DRAIN_ONE;
               // in_idx returns to 0 here so CLR and DONE both present index 0
               S_WB: begin
                  res_bit   <= agg_out_acted;
                  res_sum   <= agg_out2alu;
                  in_idx    <= '0;
                  drain_cnt <= '0;
                  if (state_nx == S_CLR) out_idx <= out_idx + OUT_ONE;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_agg_seq_ctrl.sv
// tb_agg_seq_ctrl: directed stimulus for agg_seq_ctrl, checked every cycle against a procedural
// layer model, with literal cycle-mask expectations pinning the model on each scenario.
module tb_agg_seq_ctrl;
   logic        clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0, agg_out_acted = 1;
   logic [4:0]  cfg_n_in = 0;
   logic [3:0]  cfg_n_out = 0;
   logic [11:0] agg_out2alu = 12'h0A5;
   logic        in_ready, mac_clr, mac_en, res_we, res_bit, busy, done;
   logic [4:0]  in_idx;
   logic [3:0]  res_addr;
   logic [11:0] res_sum;

   int tests = 0, fails = 0;
   bit chk_en = 0, rst_seen = 0;

   logic        e_busy, e_rdy, e_clr, e_en, e_we, e_done, e_bit, n_bit;
   logic [3:0]  e_addr;
   logic [4:0]  e_idx;
   logic [11:0] e_sum, n_sum;

   logic [63:0] clr_m, en_m, we_m, done_m, busy_m;
   logic [3:0]  addr_q[$];
   logic [4:0]  idx_q[$];

   agg_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out),
      .in_valid(in_valid), .in_ready(in_ready), .mac_clr(mac_clr), .mac_en(mac_en),
      .in_idx(in_idx), .agg_out_acted(agg_out_acted), .agg_out2alu(agg_out2alu),
      .res_we(res_we), .res_addr(res_addr), .res_bit(res_bit), .res_sum(res_sum),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge rst_n) rst_seen = 1;

   task automatic set_exp(input logic b, r, c, e, w, input logic [3:0] a, input logic d,
                          input logic [4:0] x);
      e_busy = b; e_rdy = r; e_clr = c; e_en = e; e_we = w; e_addr = a; e_done = d; e_idx = x;
   endtask

   // model time advances one clock; captured results become visible one cycle after WB
   task automatic step();
      @(posedge clk);
      #2;
      e_bit = n_bit;
      e_sum = n_sum;
   endtask

   task automatic model_layer();
      int ni, no, k;
      ni = (cfg_n_in == 0) ? 1 : (cfg_n_in > 16) ? 16 : int'(cfg_n_in);
      no = (cfg_n_out == 0) ? 1 : (cfg_n_out > 8) ? 8 : int'(cfg_n_out);
      for (int n = 0; n < no; n++) begin
         step(); if (rst_seen) return;
         set_exp(1, 0, 1, 0, 0, 0, 0, 0); if (abort) return;
         k = 0;
         while (k < ni) begin
            step(); if (rst_seen) return;
            set_exp(1, 1, 0, in_valid, 0, 0, 0, 5'(k)); if (abort) return;
            if (in_valid) k++;
         end
         for (int d = 0; d < 2; d++) begin
            step(); if (rst_seen) return;
            set_exp(1, 0, 0, 0, 0, 0, 0, 5'(ni)); if (abort) return;
         end
         step(); if (rst_seen) return;
         set_exp(1, 0, 0, 0, 1, 4'(n), 0, 5'(ni)); if (abort) return;
         n_bit = agg_out_acted;
         n_sum = agg_out2alu;
      end
      step(); if (rst_seen) return;
      set_exp(1, 0, 0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      set_exp(0, 0, 0, 0, 0, 0, 0, 0);
      e_bit = 0; e_sum = 0; n_bit = 0; n_sum = 0;
      forever begin
         step();
         if (rst_seen) begin
            rst_seen = 0; n_bit = 0; n_sum = 0; e_bit = 0; e_sum = 0;
         end
         set_exp(0, 0, 0, 0, 0, 0, 0, 0);
         if (rst_n && start && !abort) model_layer();
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         tests++;
         if ({busy, in_ready, mac_clr, mac_en, res_we, res_addr, done, in_idx, res_bit, res_sum} !==
             {e_busy, e_rdy, e_clr, e_en, e_we, e_addr, e_done, e_idx, e_bit, e_sum}) begin
            fails++;
            $display("FAIL model_cycle t=%0t busy/rdy/clr/en/we/addr/done/idx/bit/sum got %b%b%b%b%b/%0d/%b/%0d/%b/%h required %b%b%b%b%b/%0d/%b/%0d/%b/%h",
                     $time, busy, in_ready, mac_clr, mac_en, res_we, res_addr, done, in_idx, res_bit, res_sum,
                     e_busy, e_rdy, e_clr, e_en, e_we, e_addr, e_done, e_idx, e_bit, e_sum);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %0h required %0h", name, act, exp);
      end
   endtask

   // drives per-cycle masks (bit c = cycle c, cycle 0 is the call cycle) and records outputs
   task automatic run_cap(input int ncyc, input logic [63:0] vm, input logic [63:0] sm,
                          input logic [63:0] am);
      clr_m = 0; en_m = 0; we_m = 0; done_m = 0; busy_m = 0;
      addr_q.delete(); idx_q.delete();
      for (int c = 0; c < ncyc; c++) begin
         in_valid = vm[c]; start = sm[c]; abort = am[c];
         @(negedge clk);
         if (mac_clr) clr_m[c] = 1;
         if (mac_en)  en_m[c]  = 1;
         if (res_we) begin we_m[c] = 1; addr_q.push_back(res_addr); end
         if (done)    done_m[c] = 1;
         if (busy)    busy_m[c] = 1;
         idx_q.push_back(in_idx);
         @(posedge clk);
         #1;
      end
      in_valid = 0; start = 0; abort = 0;
   endtask

   localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      repeat (2) @(posedge clk);
      #3 rst_n = 1; chk_en = 1;
      @(posedge clk); #1;
      chk("reset_state", {busy, done, res_we, mac_clr, in_ready, in_idx, res_bit, res_sum}, 0);

      cfg_n_in = 3; cfg_n_out = 2;
      run_cap(17, ALL, 64'h1, 64'h0);
      chk("nom_clr", clr_m, 64'h102);
      chk("nom_en", en_m, 64'hE1C);
      chk("nom_we", we_m, 64'h4080);
      chk("nom_done", done_m, 64'h8000);
      chk("nom_addr_n", addr_q.size(), 2);
      chk("nom_addr", {addr_q[0], addr_q[1]}, 8'h01);

      cfg_n_in = 3; cfg_n_out = 1;
      run_cap(12, 64'h64, 64'h1, 64'h0);
      chk("bp_en", en_m, 64'h64);
      chk("bp_idx", {idx_q[2], idx_q[3], idx_q[4], idx_q[5], idx_q[6]},
          {5'd0, 5'd1, 5'd1, 5'd1, 5'd2});
      chk("bp_we", we_m, 64'h200);
      chk("bp_done", done_m, 64'h400);

      cfg_n_in = 0; cfg_n_out = 2;
      run_cap(13, ALL, 64'h1, 64'h0);
      chk("clamp0_en", en_m, 64'h84);
      chk("clamp0_we", we_m, 64'h420);
      chk("clamp0_done", done_m, 64'h800);

      cfg_n_in = 20; cfg_n_out = 0;
      run_cap(23, ALL, 64'h1, 64'h0);
      chk("clamp20_en", en_m, 64'h3FFFC);
      chk("clamp20_we", we_m, 64'h100000);
      chk("clamp20_done", done_m, 64'h200000);

      cfg_n_in = 1; cfg_n_out = 15;
      run_cap(43, ALL, 64'h1, 64'h0);
      chk("clamp_out_n", addr_q.size(), 8);
      chk("clamp_out_last", addr_q[7], 7);
      chk("clamp_out_done", done_m, 64'h200_0000_0000);

      cfg_n_in = 3; cfg_n_out = 2;
      run_cap(14, ALL, 64'h11, 64'h400);
      chk("abort_busy", busy_m, 64'h7FE);
      chk("abort_we", we_m, 64'h80);
      chk("abort_done", done_m, 64'h0);
      run_cap(3, ALL, 64'h1, 64'h1);
      chk("abort_over_start", busy_m, 64'h0);
      run_cap(17, ALL, 64'h1, 64'h0);
      chk("restart_we", we_m, 64'h4080);
      chk("restart_done", done_m, 64'h8000);

      agg_out2alu = 12'hF80; agg_out_acted = 0;
      cfg_n_in = 1; cfg_n_out = 1;
      run_cap(8, ALL, 64'h1, 64'h0);
      chk("cap_we", we_m, 64'h20);
      chk("cap_done", done_m, 64'h40);
      chk("cap_sum", res_sum, 12'hF80);
      chk("cap_bit", res_bit, 0);
      agg_out2alu = 12'h123; agg_out_acted = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_sum", res_sum, 12'hF80);
      chk("hold_bit", res_bit, 0);

      cfg_n_in = 3; cfg_n_out = 2;
      run_cap(4, ALL, 64'h1, 64'h0);
      in_valid = 1;
      #1 chk("pre_rst_acc", {busy, in_ready, mac_en}, 3'b111);
      #1 rst_n = 0;
      #1 chk("rst_async", {busy, in_ready, mac_en, res_we}, 0);
      chk("rst_res", {res_bit, res_sum}, 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1; in_valid = 0;
      @(negedge clk);
      chk("rst_release_idle", {busy, in_idx}, 0);
      @(posedge clk); #1;
      run_cap(17, ALL, 64'h1, 64'h0);
      chk("post_rst_done", done_m, 64'h8000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
